prbs8_checker: RTL and testbench

Receive-side partner of the switch-driven 8-bit LFSR generator. The generator uses feedback s0^s2^s3^s4 into bit 7, shifts right, and sends s[0] each step.
- The checker accepts the serial bit stream one bit per valid beat.
- It self-synchronises to the sequence and declares lock.
- Once locked, it predicts each bit, counts mismatches and detects loss of sync.
- Results go to LEDs and, optionally, to two seven-segment digits.

---
 rtl/prbs8_checker.sv | 166 ++++++++++++++++
 tb/tb_prbs8_checker.sv | 222 ++++++++++++++++++++++
 2 files changed

// File: rtl/prbs8_checker.sv
// Self-synchronising checker for the 8-bit LFSR stream (taps s0^s2^s3^s4, shift right).
// Optional seven-segment error display is built when PRBS_CHK_SEG_EN is defined.
module prbs8_checker #(
    parameter int unsigned LOCK_MATCH  = 16,
    parameter int unsigned LOSS_THRESH = 4,
    parameter int unsigned ERR_W       = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic             in_bit,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic [ERR_W-1:0] err_cnt,
    output logic             zero_det,
    output logic [7:0]       seg0,
    output logic [7:0]       seg1
);

    typedef enum logic [1:0] {
        HUNT,
        VERIFY,
        LOCK
    } state_t;

    state_t           state_q, state_d;
    logic [7:0]       win_q, win_d;
    logic [3:0]       fill_q, fill_d;
    logic [7:0]       match_q, match_d;
    logic [3:0]       miss_q, miss_d;
    logic [ERR_W-1:0] err_q, err_d;
    logic             pulse_q, pulse_d;
    logic             zero_q;
    logic             pred;

    assign pred = win_q[0] ^ win_q[2] ^ win_q[3] ^ win_q[4];

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        fill_d  = fill_q;
        match_d = match_q;
        miss_d  = miss_q;
        err_d   = err_q;
        pulse_d = 1'b0;
        if (in_valid) begin
            unique case (state_q)
                HUNT: begin
                    win_d  = {in_bit, win_q[7:1]};
                    fill_d = fill_q + 4'd1;
                    if (fill_q == 4'd7) begin
                        state_d = VERIFY;
                        match_d = '0;
                    end
                end
                VERIFY: begin
                    win_d = {in_bit, win_q[7:1]};
                    // An all-zero window predicts zeros forever, so it must never build lock.
                    if ((in_bit == pred) && (win_q != '0)) begin
                        match_d = match_q + 8'd1;
                        if (match_q + 8'd1 == 8'(LOCK_MATCH)) begin
                            state_d = LOCK;
                            miss_d  = '0;
                        end
                    end else begin
                        match_d = '0;
                    end
                end
                LOCK: begin
                    win_d = {pred, win_q[7:1]};
                    if (in_bit != pred) begin
                        pulse_d = 1'b1;
                        if (err_q != '1) begin
                            err_d = err_q + ERR_W'(1);
                        end
                        miss_d = miss_q + 4'd1;
                        if (miss_q + 4'd1 == 4'(LOSS_THRESH)) begin
                            state_d = HUNT;
                            fill_d  = '0;
                            miss_d  = '0;
                        end
                    end else begin
                        miss_d = '0;
                    end
                end
                default: state_d = HUNT;
            endcase
        end
        if (clr_err) begin
            err_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= HUNT;
            win_q   <= '0;
            fill_q  <= '0;
            match_q <= '0;
            miss_q  <= '0;
            err_q   <= '0;
            pulse_q <= 1'b0;
            zero_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            fill_q  <= fill_d;
            match_q <= match_d;
            miss_q  <= miss_d;
            err_q   <= err_d;
            pulse_q <= pulse_d;
            zero_q  <= (win_d == '0);
        end
    end

    assign locked    = (state_q == LOCK);
    assign err_pulse = pulse_q;
    assign err_cnt   = err_q;
    assign zero_det  = zero_q;

`ifdef PRBS_CHK_SEG_EN
    logic [7:0] seg0_q, seg1_q;

    // Active-low {a,b,c,d,e,f,g,dp}; dp held off.
    function automatic logic [7:0] hex_glyph(input logic [3:0] n);
        logic [7:0] g;
        unique case (n)
            4'h0: g = 8'h03;
            4'h1: g = 8'h9F;
            4'h2: g = 8'h25;
            4'h3: g = 8'h0D;
            4'h4: g = 8'h99;
            4'h5: g = 8'h49;
            4'h6: g = 8'h41;
            4'h7: g = 8'h1F;
            4'h8: g = 8'h01;
            4'h9: g = 8'h09;
            4'hA: g = 8'h11;
            4'hB: g = 8'hC1;
            4'hC: g = 8'h63;
            4'hD: g = 8'h85;
            4'hE: g = 8'h61;
            default: g = 8'h71;
        endcase
        return g;
    endfunction

    always_ff @(posedge clk) begin
        if (!rst) begin
            seg0_q <= '1;
            seg1_q <= '1;
        end else begin
            seg0_q <= hex_glyph(err_d[3:0]);
            seg1_q <= hex_glyph(err_d[7:4]);
        end
    end

    assign seg0 = seg0_q;
    assign seg1 = seg1_q;
`else
    assign seg0 = 8'hFF;
    assign seg1 = 8'hFF;
`endif

endmodule

// File: tb/tb_prbs8_checker.sv
// Scoreboard bench for prbs8_checker: driver queues expectations, negedge monitor compares.
module tb_prbs8_checker;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_bit;
    logic        clr_err;
    logic        locked;
    logic        err_pulse;
    logic [15:0] err_cnt;
    logic        zero_det;
    logic [7:0]  seg0;
    logic [7:0]  seg1;

    always #5 clk = ~clk;

    prbs8_checker #(
        .LOCK_MATCH (16),
        .LOSS_THRESH(4),
        .ERR_W      (16)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_bit   (in_bit),
        .clr_err  (clr_err),
        .locked   (locked),
        .err_pulse(err_pulse),
        .err_cnt  (err_cnt),
        .zero_det (zero_det),
        .seg0     (seg0),
        .seg1     (seg1)
    );

    typedef struct {
        string       name;
        bit          c_lock;
        bit          e_lock;
        bit          c_pulse;
        bit          e_pulse;
        bit          c_err;
        logic [15:0] e_err;
        bit          c_zero;
        bit          e_zero;
        bit          c_seg;
        logic [7:0]  e_seg0;
        logic [7:0]  e_seg1;
    } exp_t;

    exp_t        sbq[$];
    int unsigned n_chk  = 0;
    int unsigned n_pass = 0;
    logic [7:0]  gen;

    function automatic logic [7:0] glyph(input int n);
`ifdef PRBS_CHK_SEG_EN
        case (n)
            0:       return 8'h03;
            1:       return 8'h9F;
            4:       return 8'h99;
            default: return 8'hFF;
        endcase
`else
        return 8'hFF;
`endif
    endfunction

    function automatic exp_t ex(input string n, input bit cl, input bit el, input bit cp,
                                input bit ep, input bit ce, input logic [15:0] ee);
        exp_t e;
        e.name = n;   e.c_lock = cl; e.e_lock = el; e.c_pulse = cp; e.e_pulse = ep;
        e.c_err = ce; e.e_err = ee;  e.c_zero = 1'b0; e.e_zero = 1'b0;
        e.c_seg = 1'b0; e.e_seg0 = 8'hFF; e.e_seg1 = 8'hFF;
        return e;
    endfunction

    function automatic exp_t ex_reset(input string n);
        exp_t e;
        e = ex(n, 1, 0, 1, 0, 1, 16'h0000);
        e.c_zero = 1'b1; e.e_zero = 1'b0;
        e.c_seg = 1'b1;  e.e_seg0 = 8'hFF; e.e_seg1 = 8'hFF;
        return e;
    endfunction

    task automatic check(input string n, input logic [15:0] act, input logic [15:0] expv);
        n_chk++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got %h expected %h", n, act, expv);
    endtask

    initial begin
        forever begin
            @(negedge clk);
            if (sbq.size() > 0) begin
                exp_t e;
                e = sbq.pop_front();
                if (e.c_lock)  check({e.name, ".locked"},    16'(locked),    16'(e.e_lock));
                if (e.c_pulse) check({e.name, ".err_pulse"}, 16'(err_pulse), 16'(e.e_pulse));
                if (e.c_err)   check({e.name, ".err_cnt"},   err_cnt,        e.e_err);
                if (e.c_zero)  check({e.name, ".zero_det"},  16'(zero_det),  16'(e.e_zero));
                if (e.c_seg) begin
                    check({e.name, ".seg0"}, 16'(seg0), 16'(e.e_seg0));
                    check({e.name, ".seg1"}, 16'(seg1), 16'(e.e_seg1));
                end
            end
        end
    end

    task automatic beat(input bit v, input bit b, input bit clr, input exp_t e);
        in_valid = v; in_bit = b; clr_err = clr;
        @(posedge clk);
        sbq.push_back(e);
        #1;
        in_valid = 1'b0; clr_err = 1'b0;
    endtask

    task automatic do_reset(input bit v, input bit b, input string n);
        rst = 1'b0; in_valid = v; in_bit = b; clr_err = 1'b0;
        @(posedge clk);
        sbq.push_back(ex_reset(n));
        #1;
        rst = 1'b1; in_valid = 1'b0;
    endtask

    task automatic gen_next(output bit b);
        b   = gen[0];
        gen = {gen[0] ^ gen[2] ^ gen[3] ^ gen[4], gen[7:1]};
    endtask

    initial begin
        bit   b;
        exp_t e;
        rst = 1'b0; in_valid = 1'b0; in_bit = 1'b0; clr_err = 1'b0;

        // Clean acquisition from seed 8'h01: lock visible after the 24th beat
        do_reset(0, 0, "reset");
        gen = 8'h01;
        for (int i = 1; i <= 24; i++) begin
            gen_next(b);
            e = ex($sformatf("acq%0d", i), 1, (i == 24), 1, 0, 1, 16'h0000);
            if (i == 24) begin
                e.c_zero = 1'b1; e.e_zero = 1'b0;
                e.c_seg = 1'b1;  e.e_seg0 = glyph(0); e.e_seg1 = glyph(0);
            end
            beat(1, b, 0, e);
        end

        // Single flipped bit while locked
        for (int i = 0; i < 5; i++) begin
            gen_next(b); beat(1, b, 0, ex("lock_clean", 1, 1, 1, 0, 1, 16'h0000));
        end
        gen_next(b);
        e = ex("flip1", 1, 1, 1, 1, 1, 16'h0001);
        e.c_seg = 1'b1; e.e_seg0 = glyph(1); e.e_seg1 = glyph(0);
        beat(1, ~b, 0, e);
        for (int i = 0; i < 5; i++) begin
            gen_next(b); beat(1, b, 0, ex("post_flip", 1, 1, 1, 0, 1, 16'h0001));
        end

        // Clear, then a 4-bit burst drops lock; clean stream relocks in 24 beats
        gen_next(b); beat(1, b, 1, ex("clr", 1, 1, 1, 0, 1, 16'h0000));
        for (int i = 1; i <= 4; i++) begin
            gen_next(b);
            e = ex($sformatf("burst%0d", i), 1, (i < 4), 1, 1, 1, 16'(i));
            if (i == 4) begin
                e.c_seg = 1'b1; e.e_seg0 = glyph(4); e.e_seg1 = glyph(0);
            end
            beat(1, ~b, 0, e);
        end
        for (int i = 1; i <= 24; i++) begin
            gen_next(b);
            beat(1, b, 0, ex($sformatf("relock%0d", i), 1, (i == 24), 1, 0, 1, 16'h0004));
        end

        // Clear beats a simultaneous mismatch; the pulse still fires
        gen_next(b); beat(1, ~b, 1, ex("clr_vs_err", 1, 1, 1, 1, 1, 16'h0000));
        gen_next(b); beat(1, b, 0, ex("after_clr", 1, 1, 1, 0, 1, 16'h0000));

        // Reset while locked, with a corrupted beat presented
        gen_next(b);
        do_reset(1, ~b, "reset_mid_lock");

        // All-zero stream never locks
        for (int i = 1; i <= 40; i++) begin
            e = ex($sformatf("zeros%0d", i), 1, 0, 1, 0, 1, 16'h0000);
            if (i == 40) begin
                e.c_zero = 1'b1; e.e_zero = 1'b1;
            end
            beat(1, 0, 0, e);
        end

        // Mismatch at VERIFY match 10, with in_valid gaps during re-verification
        do_reset(0, 0, "reset2");
        gen = 8'h01;
        for (int i = 1; i <= 18; i++) begin
            gen_next(b); beat(1, b, 0, ex("pre_mis", 1, 0, 1, 0, 1, 16'h0000));
        end
        gen_next(b); beat(1, ~b, 0, ex("verify_mis", 1, 0, 1, 0, 1, 16'h0000));
        for (int k = 1; k <= 24; k++) begin
            if (k == 12 || k == 23) begin
                for (int g = 0; g < 3; g++)
                    beat(0, g[0], 0, ex("gap_verify", 1, 0, 1, 0, 1, 16'h0000));
            end
            gen_next(b);
            beat(1, b, 0, ex($sformatf("reverify%0d", k), 1, (k == 24), 1, 0, 1, 16'h0000));
        end
        for (int g = 0; g < 3; g++) begin
            gen_next(b);
            beat(0, ~b, 0, ex("gap_lock", 1, 1, 1, 0, 1, 16'h0000));
            gen = {gen[6:0], gen[7]} ^ gen;
        end

        repeat (2) @(posedge clk);
        n_chk++;
        if (sbq.size() == 0) n_pass++;
        else $display("FAIL drain: got %0d pending expected 0", sbq.size());
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
